// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
package fifo_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Explicit wrap so non-power-of-two depths index the array correctly.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one combinational read port.
// No reset; contents are only meaningful between the FIFO pointers.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with count, almost-full/empty, sticky error flags and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered (1 clock).
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1),
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  fifo_err_t             err_q, err_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // A same-cycle write never makes an empty FIFO readable, but a read frees a slot for a write.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), 32'(DEPTH)));
      if (rd_acc) rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), 32'(DEPTH)));
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      err_d.overflow  = err_q.overflow  | (wr_en & ~wr_acc);
      err_d.underflow = err_q.underflow | (rd_en & ~rd_acc);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc & ~flush),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = ram_rdata;
  assign rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;

  // data_out holds across idle cycles and flush; only a real pop updates it.
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    if (!flush && rd_acc) begin
      data_out_d = ram_rdata;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: DEPTH=16 instance for flags/errors/flush/reset, DEPTH=5 instance for pointer wrap.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       rd_valid, full, empty, af, ae, ovf, unf;
  logic [4:0] count;

  logic       f5_flush = 1'b0, f5_wr_en = 1'b0, f5_rd_en = 1'b0;
  logic [7:0] f5_din = 8'h00;
  logic [7:0] f5_dout;
  logic       f5_rd_valid, f5_full, f5_empty, f5_af, f5_ae, f5_ovf, f5_unf;
  logic [2:0] f5_count;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16)) u16 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(din), .rd_en(rd_en),
    .data_out(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .count(count), .overflow(ovf), .underflow(unf)
  );

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .flush(f5_flush), .wr_en(f5_wr_en), .data_in(f5_din), .rd_en(f5_rd_en),
    .data_out(f5_dout), .rd_valid(f5_rd_valid), .full(f5_full), .empty(f5_empty),
    .almost_full(f5_af), .almost_empty(f5_ae), .count(f5_count), .overflow(f5_ovf), .underflow(f5_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if ({empty, full, ae, af} !== 4'b1010) begin errors++; $display("FAIL reset_flags: got %b want 1010", {empty, full, ae, af}); end
    checks++; if ({ovf, unf, rd_valid} !== 3'b000) begin errors++; $display("FAIL reset_err_valid: got %b want 000", {ovf, unf, rd_valid}); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1;
      din   = 8'(i);
      tick();
      checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
      checks++; if (af !== (i >= 14)) begin errors++; $display("FAIL fill_af[%0d]: got %b want %b", i, af, (i >= 14)); end
      checks++; if (ae !== (i <= 2)) begin errors++; $display("FAIL fill_ae[%0d]: got %b want %b", i, ae, (i <= 2)); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 16)); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", ovf); end
    din = 8'hEE;
    tick();
    wr_en = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", ovf); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d want 16", count); end
    tick();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL drain_head[%0d]: got %h want %h", i, dout, 8'(i)); end
`endif
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, dout, 8'(i)); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", i, rd_valid); end
`endif
    end
    rd_en = 1'b0;
    tick();
    checks++; if ({empty, count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL drain_empty: got %b/%0d want 1/0", empty, count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_idle_valid: got %b want 0", rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (dout !== 8'h10) begin errors++; $display("FAIL drain_hold: got %h want 10", dout); end
`endif
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL drain_no_unf: got %b want 0", unf); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", unf); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_simultaneous();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({ovf, unf, count} !== {2'b00, 5'd0}) begin errors++; $display("FAIL flush_clear: got %b%b/%0d want 00/0", ovf, unf, count); end
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h20 + i);
      tick();
    end
    rd_en = 1'b1;
    din   = 8'h99;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL simul_full_count: got %0d want 16", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL simul_full_ovf: got %b want 0", ovf); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (dout !== 8'h20) begin errors++; $display("FAIL simul_full_data: got %h want 20", dout); end
`else
    checks++; if (dout !== 8'h21) begin errors++; $display("FAIL simul_full_head: got %h want 21", dout); end
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL simul_empty_count: got %0d want 1", count); end
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL simul_empty_unf: got %b want 1", unf); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL simul_empty_valid: got %b want 0", rd_valid); end
`else
    checks++; if (dout !== 8'h77) begin errors++; $display("FAIL simul_empty_head: got %h want 77", dout); end
`endif
  endtask

  task automatic test_wrap_depth5();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        f5_wr_en = 1'b1;
        f5_din   = 8'(r * 16 + k + 1);
        tick();
      end
      f5_wr_en = 1'b0;
      checks++; if ({f5_full, f5_count} !== {1'b1, 3'd5}) begin errors++; $display("FAIL wrap_full[%0d]: got %b/%0d want 1/5", r, f5_full, f5_count); end
      for (int k = 0; k < 5; k++) begin
        f5_rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        checks++; if (f5_dout !== 8'(r * 16 + k + 1)) begin errors++; $display("FAIL wrap_head[%0d.%0d]: got %h want %h", r, k, f5_dout, 8'(r * 16 + k + 1)); end
`endif
        tick();
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (f5_dout !== 8'(r * 16 + k + 1)) begin errors++; $display("FAIL wrap_data[%0d.%0d]: got %h want %h", r, k, f5_dout, 8'(r * 16 + k + 1)); end
`endif
      end
      f5_rd_en = 1'b0;
      checks++; if ({f5_empty, f5_ovf, f5_unf} !== 3'b100) begin errors++; $display("FAIL wrap_end[%0d]: got %b want 100", r, {f5_empty, f5_ovf, f5_unf}); end
    end
  endtask

  task automatic test_async_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h40 + i);
      tick();
    end
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL areset_pre_count: got %0d want 7", count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", count); end
    checks++; if ({empty, ae, full, af} !== 4'b1100) begin errors++; $display("FAIL areset_flags: got %b want 1100", {empty, ae, full, af}); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL areset_dout: got %h want 00", dout); end
`endif
    wr_en = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    checks++; if ({empty, count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL areset_release: got %b/%0d want 1/0", empty, count); end
  endtask

  task automatic test_flush_drops_write();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h50 + i);
      tick();
    end
    flush = 1'b1;
    din   = 8'h5F;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    checks++; if ({empty, count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL flush_empty: got %b/%0d want 1/0", empty, count); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL flush_write_dropped: got unf=%b want 1", unf); end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b1;
    din   = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++; if ({dout, rd_valid} !== {8'hA5, 1'b1}) begin errors++; $display("FAIL fwft_head: got %h/%b want a5/1", dout, rd_valid); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if ({empty, rd_valid} !== 2'b10) begin errors++; $display("FAIL fwft_pop: got %b want 10", {empty, rd_valid}); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_wrap_depth5();
    test_async_reset();
    test_flush_drops_write();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO with an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is the successor to the team's basic synchronous FIFO and the standard buffering element between same-clock producer/consumer blocks. The storage array is separated from the pointer/flag control.

Parameters:
DATA_WIDTH, 8, width of each data word.
DEPTH, 16, number of entries; any value >= 2; power of two not required.
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.
CNT_W, $clog2(DEPTH+1), derived width of count; not overridden.
PTR_W, $clog2(DEPTH), derived pointer width; not overridden.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  reset; asynchronous, active-low (asserted at 0).
flush  in  1  synchronous clear of pointers, count and error flags.
wr_en  in  1  write request.
data_in  in  DATA_WIDTH  write data.
rd_en  in  1  read request.
data_out  out  DATA_WIDTH  read data.
rd_valid  out  1  data_out holds newly popped data (registered mode).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  CNT_W  current occupancy, 0..DEPTH.
overflow  out  1  sticky: write rejected.
underflow  out  1  sticky: read rejected.

Behaviour:
- Reset (rst = 0, asynchronous): wr_ptr, rd_ptr and count = 0; data_out = 0; rd_valid = 0; overflow = underflow = 0. Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0. Array contents are not reset.
- Reset mid-operation discards all contents immediately. No state is retained on release.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc). A write into a full FIFO is accepted only if a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_en & !empty. A write arriving in the same cycle does not make an empty FIFO readable.
- Pointers advance by 1 per accepted access and wrap from DEPTH-1 to 0. This is an explicit compare, not natural overflow, so non-power-of-two DEPTH works.
- count next value:
  - count+1 on wr_acc & !rd_acc;
  - count-1 on rd_acc & !wr_acc;
  - otherwise unchanged.
- All flags decode combinationally from the registered count.
- Registered read mode (default):
  - On rd_acc, data_out <= mem[rd_ptr] and rd_valid = 1 in the next cycle. Read latency is 1 clock.
  - data_out holds its value when there is no read. rd_valid is 0 in any cycle that does not follow an accepted read.
- Write-to-read latency: data written in cycle N is poppable from cycle N+1 (empty deasserts at N+1).
- Error flags:
  - overflow sets when wr_en & !wr_acc.
  - underflow sets when rd_en & !rd_acc.
  - Both are sticky until flush or reset.
  - Rejected accesses change no other state.
- flush (synchronous, priority over wr_en/rd_en): pointers, count, rd_valid and error flags are cleared on the next edge. data_out is held.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally whenever !empty, so the head word is visible before it is popped.
  - rd_en pops the head; the next word appears in the same cycle after the pointer update.
  - rd_valid = !empty.
  - data_out is don't-care when empty.
- Undefined: registered read mode as described in Behaviour.
- Flag, count, error and flush behaviour is identical in both modes.

Decomposition:
- Package fifo_pkg: fifo_err_t struct {overflow, underflow}; a next_ptr wrap function (ptr, depth). Default thresholds are kept in the module parameters.
- Sub-module sync_fifo_ram: a DEPTH x DATA_WIDTH array with one write port (we, waddr, wdata) and a combinational read address port. It has no reset.
- Pointers, count, flags and data_out register stay in sync_fifo_flags.

Test Plan:
- DEPTH=16: write 16 words 0x01..0x10 with no reads -> full=1 and count=16 after the 16th edge; almost_full asserts at count=14; a 17th write sets overflow=1 with count still 16.
- From full: read 16 times -> data_out is 0x01..0x10 in order, each 1 cycle after rd_en with rd_valid=1; then empty=1; a further rd_en sets underflow=1.
- Simultaneous wr_en & rd_en on a full FIFO -> both accepted, count stays 16, no overflow. On an empty FIFO -> write only, count becomes 1, underflow=1.
- DEPTH=5 (non-power-of-two): 3 rounds of 5 writes then 5 reads -> pointers wrap cleanly and data order is preserved each round.
- Assert rst=0 asynchronously mid-burst with count=7 -> outputs return to reset values before the next clock edge. Separately, flush=1 with wr_en=1 -> count=0 and empty=1 next cycle, and the write is dropped.
- With SYNC_FIFO_FWFT_EN defined: write 0xA5 -> data_out=0xA5 and rd_valid=1 one cycle later without rd_en; rd_en -> empty=1.
